// File: rtl/vx_operand_fetch.sv
// Issue-side operand fetch: drives GPR read addresses, captures the response, and queues operand bundles for dispatch.
// Optional feature macro GPR_BYPASS_EN: merge a same-cycle writeback that the RAM read returned as stale data.

module vx_operand_fetch #(
  parameter  int CORE_ID     = 0,
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_WARPS   = 4,
  parameter  int NUM_REGS    = 32,
  parameter  int META_W      = 64,
  parameter  int FIFO_DEPTH  = 3,
  localparam int WIDW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int RW          = $clog2(NUM_REGS),
  localparam int DW          = NUM_THREADS * 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ibuf_valid,
  output logic                   ibuf_ready,
  input  logic [WIDW-1:0]        ibuf_wid,
  input  logic [NUM_THREADS-1:0] ibuf_tmask,
  input  logic [RW-1:0]          ibuf_rs1,
  input  logic [RW-1:0]          ibuf_rs2,
  input  logic [RW-1:0]          ibuf_rs3,
  input  logic [META_W-1:0]      ibuf_meta,
  output logic [WIDW-1:0]        gpr_req_wid,
  output logic [RW-1:0]          gpr_req_rs1,
  output logic [RW-1:0]          gpr_req_rs2,
  output logic [RW-1:0]          gpr_req_rs3,
  input  logic [DW-1:0]          gpr_rsp_rs1_data,
  input  logic [DW-1:0]          gpr_rsp_rs2_data,
  input  logic [DW-1:0]          gpr_rsp_rs3_data,
  input  logic                   wb_valid,
  input  logic [WIDW-1:0]        wb_wid,
  input  logic [RW-1:0]          wb_rd,
  input  logic [NUM_THREADS-1:0] wb_tmask,
  input  logic [DW-1:0]          wb_data,
  output logic                   disp_valid,
  input  logic                   disp_ready,
  output logic [WIDW-1:0]        disp_wid,
  output logic [NUM_THREADS-1:0] disp_tmask,
  output logic [META_W-1:0]      disp_meta,
  output logic [DW-1:0]          disp_rs1_data,
  output logic [DW-1:0]          disp_rs2_data,
  output logic [DW-1:0]          disp_rs3_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic                   accept_s, push_s, pop_s;
  logic                   s1_valid_q;
  logic [WIDW-1:0]        s1_wid_q;
  logic [NUM_THREADS-1:0] s1_tmask_q;
  logic [META_W-1:0]      s1_meta_q;
  logic [DW-1:0]          op1_s, op2_s, op3_s;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [OCC_W-1:0]       occ_s;
  logic                   unused_core_s;

  logic [WIDW-1:0]        fifo_wid_q   [FIFO_DEPTH];
  logic [NUM_THREADS-1:0] fifo_tmask_q [FIFO_DEPTH];
  logic [META_W-1:0]      fifo_meta_q  [FIFO_DEPTH];
  logic [DW-1:0]          fifo_rs1_q   [FIFO_DEPTH];
  logic [DW-1:0]          fifo_rs2_q   [FIFO_DEPTH];
  logic [DW-1:0]          fifo_rs3_q   [FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  assign unused_core_s = (CORE_ID != 0);

  assign gpr_req_wid = ibuf_wid;
  assign gpr_req_rs1 = ibuf_rs1;
  assign gpr_req_rs2 = ibuf_rs2;
  assign gpr_req_rs3 = ibuf_rs3;

  // Stage-1 occupancy is reserved so the unconditional push can never overflow.
  assign occ_s      = OCC_W'(count_q) + OCC_W'(s1_valid_q);
  assign ibuf_ready = reset && (occ_s < OCC_W'(FIFO_DEPTH));
  assign accept_s   = ibuf_valid && ibuf_ready;
  assign push_s     = s1_valid_q;
  assign disp_valid = reset && (count_q != '0);
  assign pop_s      = disp_valid && disp_ready;

`ifdef GPR_BYPASS_EN
  logic [2:0]             hit_q, hit_d;
  logic                   wb_match_s;
  logic [NUM_THREADS-1:0] wb_tmask_q;
  logic [DW-1:0]          wb_data_q;

  function automatic logic [DW-1:0] merge_lanes(input logic hit, input logic [NUM_THREADS-1:0] mask,
                                                input logic [DW-1:0] wb, input logic [DW-1:0] rsp);
    logic [DW-1:0] r;
    r = rsp;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (hit && mask[i]) r[i*32 +: 32] = wb[i*32 +: 32];
      else r[i*32 +: 32] = rsp[i*32 +: 32];
    end
    return r;
  endfunction

  // r0 is hardwired in the RAM, so a writeback to it must never be forwarded.
  always_comb begin
    wb_match_s = wb_valid && (wb_rd != '0) && (wb_wid == ibuf_wid);
    hit_d      = {wb_match_s && (wb_rd == ibuf_rs3),
                  wb_match_s && (wb_rd == ibuf_rs2),
                  wb_match_s && (wb_rd == ibuf_rs1)};
  end

  always_ff @(posedge clk) begin
    if (!reset) hit_q <= '0;
    else if (accept_s) hit_q <= hit_d;
    else hit_q <= hit_q;
  end

  always_ff @(posedge clk) begin
    if (accept_s) begin
      wb_tmask_q <= wb_tmask;
      wb_data_q  <= wb_data;
    end
  end

  assign op1_s = merge_lanes(hit_q[0], wb_tmask_q, wb_data_q, gpr_rsp_rs1_data);
  assign op2_s = merge_lanes(hit_q[1], wb_tmask_q, wb_data_q, gpr_rsp_rs2_data);
  assign op3_s = merge_lanes(hit_q[2], wb_tmask_q, wb_data_q, gpr_rsp_rs3_data);
`else
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_valid, wb_wid, wb_rd, wb_tmask, wb_data};
  assign op1_s = gpr_rsp_rs1_data;
  assign op2_s = gpr_rsp_rs2_data;
  assign op3_s = gpr_rsp_rs3_data;
`endif

  always_comb begin
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= accept_s;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_s) begin
      s1_wid_q   <= ibuf_wid;
      s1_tmask_q <= ibuf_tmask;
      s1_meta_q  <= ibuf_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_wid_q[wr_ptr_q]   <= s1_wid_q;
      fifo_tmask_q[wr_ptr_q] <= s1_tmask_q;
      fifo_meta_q[wr_ptr_q]  <= s1_meta_q;
      fifo_rs1_q[wr_ptr_q]   <= op1_s;
      fifo_rs2_q[wr_ptr_q]   <= op2_s;
      fifo_rs3_q[wr_ptr_q]   <= op3_s;
    end
  end

  assign disp_wid      = fifo_wid_q[rd_ptr_q];
  assign disp_tmask    = fifo_tmask_q[rd_ptr_q];
  assign disp_meta     = fifo_meta_q[rd_ptr_q];
  assign disp_rs1_data = fifo_rs1_q[rd_ptr_q];
  assign disp_rs2_data = fifo_rs2_q[rd_ptr_q];
  assign disp_rs3_data = fifo_rs3_q[rd_ptr_q];

endmodule

// File: tb/tb_vx_operand_fetch.sv
// Directed self-checking bench for vx_operand_fetch (default parameters).
// Expected bypass results depend on whether GPR_BYPASS_EN is defined for the build.

module tb_vx_operand_fetch;

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ibuf_valid = 1'b0;
  logic         ibuf_ready;
  logic [1:0]   ibuf_wid = '0;
  logic [3:0]   ibuf_tmask = '0;
  logic [4:0]   ibuf_rs1 = '0, ibuf_rs2 = '0, ibuf_rs3 = '0;
  logic [63:0]  ibuf_meta = '0;
  logic [1:0]   gpr_req_wid;
  logic [4:0]   gpr_req_rs1, gpr_req_rs2, gpr_req_rs3;
  logic [127:0] gpr_rsp_rs1_data = '0, gpr_rsp_rs2_data = '0, gpr_rsp_rs3_data = '0;
  logic         wb_valid = 1'b0;
  logic [1:0]   wb_wid = '0;
  logic [4:0]   wb_rd = '0;
  logic [3:0]   wb_tmask = '0;
  logic [127:0] wb_data = '0;
  logic         disp_valid;
  logic         disp_ready = 1'b0;
  logic [1:0]   disp_wid;
  logic [3:0]   disp_tmask;
  logic [63:0]  disp_meta;
  logic [127:0] disp_rs1_data, disp_rs2_data, disp_rs3_data;

  int checks = 0;
  int errors = 0;

  vx_operand_fetch dut (
    .clk(clk), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_wid(ibuf_wid), .ibuf_tmask(ibuf_tmask),
    .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3), .ibuf_meta(ibuf_meta),
    .gpr_req_wid(gpr_req_wid), .gpr_req_rs1(gpr_req_rs1), .gpr_req_rs2(gpr_req_rs2), .gpr_req_rs3(gpr_req_rs3),
    .gpr_rsp_rs1_data(gpr_rsp_rs1_data), .gpr_rsp_rs2_data(gpr_rsp_rs2_data), .gpr_rsp_rs3_data(gpr_rsp_rs3_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_wid(disp_wid), .disp_tmask(disp_tmask),
    .disp_meta(disp_meta), .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data), .disp_rs3_data(disp_rs3_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] pat(input int idx, input int k);
    logic [127:0] v;
    for (int l = 0; l < 4; l++) v[l*32 +: 32] = 32'h5000_0000 + 32'(idx * 256 + k * 16 + l);
    return v;
  endfunction

  function automatic logic [63:0] meta_of(input int idx);
    return 64'hC0DE_0000_0000_0000 + 64'(idx);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ibuf(input logic v, input int idx);
    ibuf_valid = v;
    ibuf_wid   = 2'(idx);
    ibuf_tmask = 4'(idx) ^ 4'hF;
    ibuf_rs1   = 5'(idx + 1);
    ibuf_rs2   = 5'(idx + 2);
    ibuf_rs3   = 5'(idx + 3);
    ibuf_meta  = meta_of(idx);
  endtask

  task automatic drive_rsp(input int idx);
    gpr_rsp_rs1_data = pat(idx, 1);
    gpr_rsp_rs2_data = pat(idx, 2);
    gpr_rsp_rs3_data = pat(idx, 3);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid: got %b want 0", disp_valid); end
    checks++; if (ibuf_ready !== 1'b0) begin errors++; $display("FAIL rst_ibuf_ready: got %b want 0", ibuf_ready); end
    ibuf_wid = 2'd3; ibuf_rs1 = 5'd9; ibuf_rs2 = 5'd10; ibuf_rs3 = 5'd31;
    #1;
    checks++; if ({gpr_req_wid, gpr_req_rs1, gpr_req_rs2, gpr_req_rs3} !== {2'd3, 5'd9, 5'd10, 5'd31}) begin
      errors++; $display("FAIL req_passthru: got %h %h %h %h want 3 9 a 1f", gpr_req_wid, gpr_req_rs1, gpr_req_rs2, gpr_req_rs3);
    end
    reset = 1'b1;
    step();
    checks++; if (ibuf_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", ibuf_ready); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", disp_valid); end
  endtask

  task automatic test_single();
    disp_ready = 1'b0;
    ibuf_valid = 1'b1; ibuf_wid = 2'd1; ibuf_tmask = 4'hB;
    ibuf_rs1 = 5'd5; ibuf_rs2 = 5'd6; ibuf_rs3 = 5'd8; ibuf_meta = 64'hDEAD_BEEF_0123_4567;
    step();
    ibuf_valid = 1'b0;
    gpr_rsp_rs1_data = {4{32'h1111_1111}};
    gpr_rsp_rs2_data = {4{32'h2222_2222}};
    gpr_rsp_rs3_data = {4{32'h3333_3333}};
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %b want 0", disp_valid); end
    step();
    gpr_rsp_rs1_data = '0; gpr_rsp_rs2_data = '0; gpr_rsp_rs3_data = '0;
    for (int h = 0; h < 2; h++) begin
      checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", h, disp_valid); end
      checks++; if (disp_rs1_data !== {4{32'h1111_1111}}) begin errors++; $display("FAIL single_rs1[%0d]: got %h", h, disp_rs1_data); end
      checks++; if (disp_rs3_data !== {4{32'h3333_3333}}) begin errors++; $display("FAIL single_rs3[%0d]: got %h", h, disp_rs3_data); end
      checks++; if ({disp_wid, disp_tmask, disp_meta} !== {2'd1, 4'hB, 64'hDEAD_BEEF_0123_4567}) begin
        errors++; $display("FAIL single_fields[%0d]: got wid=%h tmask=%h meta=%h", h, disp_wid, disp_tmask, disp_meta);
      end
      step();
    end
    disp_ready = 1'b1;
    step();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", disp_valid); end
  endtask

  task automatic test_back_to_back();
    disp_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c < 8) drive_ibuf(1'b1, c); else drive_ibuf(1'b0, 0);
      if (c >= 1 && c <= 8) drive_rsp(c - 1);
      #1;
      if (c < 8) begin
        checks++; if (ibuf_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", c, ibuf_ready); end
      end
      if (c >= 2 && c <= 9) begin
        checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", c, disp_valid); end
        checks++; if (disp_meta !== meta_of(c - 2)) begin errors++; $display("FAIL b2b_meta[%0d]: got %h want %h", c, disp_meta, meta_of(c - 2)); end
        checks++; if (disp_rs2_data !== pat(c - 2, 2)) begin errors++; $display("FAIL b2b_rs2[%0d]: got %h want %h", c, disp_rs2_data, pat(c - 2, 2)); end
        checks++; if (disp_tmask !== (4'(c - 2) ^ 4'hF)) begin errors++; $display("FAIL b2b_tmask[%0d]: got %h", c, disp_tmask); end
      end else begin
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got %b want 0", c, disp_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    disp_ready = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      drive_ibuf(1'b1, 20 + c);
      if (c >= 1 && c <= 3) drive_rsp(20 + c - 1);
      #1;
      checks++; if (ibuf_ready !== (c < 3)) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", c, ibuf_ready, (c < 3)); end
      step();
    end
    drive_ibuf(1'b0, 0);
    disp_ready = 1'b1;
    #1;
    checks++; if (ibuf_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", ibuf_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, disp_valid); end
      checks++; if (disp_meta !== meta_of(20 + i)) begin errors++; $display("FAIL bp_drain_meta[%0d]: got %h want %h", i, disp_meta, meta_of(20 + i)); end
      checks++; if (disp_rs1_data !== pat(20 + i, 1)) begin errors++; $display("FAIL bp_drain_rs1[%0d]: got %h", i, disp_rs1_data); end
      step();
    end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", disp_valid); end
    checks++; if (ibuf_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", ibuf_ready); end
  endtask

  task automatic test_bypass();
    logic [4:0]   t_rs1 [4] = '{5'd1, 5'd1, 5'd1, 5'd7};
    logic [4:0]   t_rs2 [4] = '{5'd7, 5'd0, 5'd7, 5'd7};
    logic [4:0]   t_rs3 [4] = '{5'd3, 5'd3, 5'd3, 5'd7};
    logic [1:0]   t_wid [4] = '{2'd2, 2'd2, 2'd3, 2'd2};
    logic [4:0]   t_rd  [4] = '{5'd7, 5'd0, 5'd7, 5'd7};
    logic [2:0]   t_hit [4] = '{3'b010, 3'b000, 3'b000, 3'b111};
    logic [127:0] merged, plain, exp;
    logic [2:0]   h;
    merged = 128'h00000001_AAAA0000_00000001_AAAA0000;
    plain  = {4{32'h0000_0001}};
    disp_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      ibuf_valid = 1'b1; ibuf_wid = 2'd2; ibuf_tmask = 4'hF; ibuf_meta = meta_of(60 + t);
      ibuf_rs1 = t_rs1[t]; ibuf_rs2 = t_rs2[t]; ibuf_rs3 = t_rs3[t];
      wb_valid = 1'b1; wb_wid = t_wid[t]; wb_rd = t_rd[t]; wb_tmask = 4'b0101; wb_data = {4{32'hAAAA_0000}};
      step();
      ibuf_valid = 1'b0;
      wb_wid = 2'd2; wb_rd = 5'd7; wb_tmask = 4'hF; wb_data = {4{32'hBBBB_BBBB}};
      gpr_rsp_rs1_data = plain; gpr_rsp_rs2_data = plain; gpr_rsp_rs3_data = plain;
      step();
      wb_valid = 1'b0;
      h = BYP ? t_hit[t] : 3'b000;
      exp = h[0] ? merged : plain;
      checks++; if (disp_rs1_data !== exp) begin errors++; $display("FAIL byp_rs1[%0d]: got %h want %h", t, disp_rs1_data, exp); end
      exp = h[1] ? merged : plain;
      checks++; if (disp_rs2_data !== exp) begin errors++; $display("FAIL byp_rs2[%0d]: got %h want %h", t, disp_rs2_data, exp); end
      exp = h[2] ? merged : plain;
      checks++; if (disp_rs3_data !== exp) begin errors++; $display("FAIL byp_rs3[%0d]: got %h want %h", t, disp_rs3_data, exp); end
      disp_ready = 1'b1;
      step();
      disp_ready = 1'b0;
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL byp_pop[%0d]: got %b want 0", t, disp_valid); end
    end
  endtask

  task automatic test_reset_mid();
    disp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_ibuf(1'b1, 40 + c);
      if (c >= 1) drive_rsp(40 + c - 1);
      #1;
      checks++; if (ibuf_ready !== 1'b1) begin errors++; $display("FAIL rm_ready[%0d]: got %b want 1", c, ibuf_ready); end
      step();
    end
    drive_ibuf(1'b0, 0);
    drive_rsp(42);
    #1;
    checks++; if ({ibuf_ready, disp_valid, disp_meta} !== {1'b0, 1'b1, meta_of(40)}) begin
      errors++; $display("FAIL rm_pre: got ready=%b valid=%b meta=%h", ibuf_ready, disp_valid, disp_meta);
    end
    reset = 1'b0;
    step();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rm_in_rst_valid: got %b want 0", disp_valid); end
    checks++; if (ibuf_ready !== 1'b0) begin errors++; $display("FAIL rm_in_rst_ready: got %b want 0", ibuf_ready); end
    reset = 1'b1;
    step();
    checks++; if (ibuf_ready !== 1'b1) begin errors++; $display("FAIL rm_rel_ready: got %b want 1", ibuf_ready); end
    disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d]: got %b want 0", i, disp_valid); end
      step();
    end
    drive_ibuf(1'b1, 50);
    step();
    drive_ibuf(1'b0, 0);
    drive_rsp(50);
    step();
    checks++; if ({disp_valid, disp_meta} !== {1'b1, meta_of(50)}) begin
      errors++; $display("FAIL rm_fresh: got valid=%b meta=%h want 1 %h", disp_valid, disp_meta, meta_of(50));
    end
    checks++; if (disp_rs2_data !== pat(50, 2)) begin errors++; $display("FAIL rm_fresh_rs2: got %h want %h", disp_rs2_data, pat(50, 2)); end
    step();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rm_final: got %b want 0", disp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
